clut_cache_loader: RTL and testbench
====================================

// Module: clut_cache_loader
// PURPOSE
//  Fill controller upstream of the CLUT cache RAM (16 blocks x 8 words x 32b).
//  Checks which 16-colour CLUT blocks the current primitive needs: 1 block for 4bpp, 16 for 8bpp.
//  Fetches each missing block from VRAM as an 8-beat 32b burst and writes it into the cache.
//  Tells the texel pipe when the whole CLUT is resident.
// PARAMETERS
//  BURST_LEN  8  words per block; fixed by cache geometry, not to be overridden
// PORTS
//  i_clk             in   1   clock
//  i_rst             in   1   synchronous reset, active-high
//  i_loadReq         in   1   start CLUT load; sampled only in IDLE
//  i_clutX           in   6   CLUT X in 16-halfword units
//  i_clutY           in   9   CLUT VRAM row
//  i_is8bpp          in   1   1: 16 blocks needed; 0: 1 block needed
//  i_invalidate      in   1   VRAM written under cache; drop all valid bits
//  o_busy            out  1   FSM not in IDLE
//  o_done            out  1   1-cycle pulse: requested CLUT fully resident
//  o_memReq          out  1   burst request; held until i_memAck
//  o_memAddr         out  18  32b word address {row[8:0], col[5:0], 3'b000}
//  i_memAck          in   1   request accepted (same cycle as o_memReq)
//  i_dataValid       in   1   one burst beat on i_data
//  i_data            in   32  two 16b colours, low halfword = even entry
//  o_write           out  1   cache write strobe
//  o_writeBlockIndex out  4   cache block = col[3:0]
//  o_writeIdxInBlk   out  3   beat index 0..7
//  o_Colors          out  32  write data (registered copy of i_data)
// BEHAVIOUR
//  - Block tagging:
//    - Column col (6b) maps to block col[3:0].
//    - Per block: valid bit + 11b tag {col[5:4], row}.
//    - Hit = valid & tag match.
//  - Columns to load: col = clutX + n (mod 64).
//    - n = 0 only when !is8bpp; n = 0..15 when is8bpp.
//    - The 16 columns hit 16 distinct blocks; wrap 63->0 is legal.
//  - FSM: IDLE, CHECK, REQ, RECV, DONE.
//    - IDLE: i_loadReq=1 latches X/Y/bpp, n=0 -> CHECK.
//    - CHECK (1 cycle per block):
//      - hit: n++, stay in CHECK; after the last n -> DONE.
//      - miss -> REQ.
//    - REQ: o_memReq=1 with o_memAddr stable; i_memAck -> RECV, beat=0.
//    - RECV: on each i_dataValid, next cycle emits:
//      - o_write=1, o_writeIdxInBlk=beat, o_writeBlockIndex=col[3:0], o_Colors=data.
//      - beat++.
//      - On the 8th beat, set valid+tag for the block, n++, -> CHECK or DONE.
//    - DONE: o_done=1 for 1 cycle -> IDLE.
//  - Timing:
//    - Fully-hit 4bpp request: req cycle 0, CHECK 1, o_done=1 in cycle 2.
//    - Data gaps (i_dataValid low) are allowed; beats are never dropped.
//  - Invalidate:
//    - i_invalidate clears all valid bits in the next cycle.
//    - If it arrives during REQ/RECV: finish the burst, do NOT set that block's valid bit, restart CHECK at n=0.
//    - If it arrives in the same cycle as an 8th-beat completion, invalidate wins.
//    - In CHECK it also forces restart at n=0.
//  - i_loadReq while o_busy=1 is ignored; the pipe must wait for o_done.
//  - Reset:
//    - Outputs after reset: o_busy, o_done, o_memReq, o_write = 0; o_memAddr, o_writeBlockIndex, o_writeIdxInBlk, o_Colors = 0.
//    - All valid bits = 0; FSM returns to IDLE.
//    - Reset mid-burst abandons it; later beats arriving in IDLE are ignored (no o_write).
//  - i_data width fixed at 32b; no byte enables; addresses do not wrap rows.
// TESTING
//  - Cold 4bpp: X=5,Y=480 -> one burst, o_memAddr=0x3C028, 8 writes to blk5 idx0..7, o_done.
//  - Repeat same 4bpp request -> no o_memReq; o_done exactly 2 cycles after i_loadReq.
//  - 8bpp X=60,Y=0 cold -> 16 bursts, cols 60..63,0..11; blocks 12,13,14,15,0..11; data matches per beat.
//  - 8bpp X=60 after 4bpp X=0,Y=0 loaded -> blk0 skipped, exactly 15 bursts.
//  - i_invalidate during 4th beat of 4bpp load -> burst completes, then re-fetched, 16 writes total, o_done once.
//  - i_rst at beat 3 -> all outputs 0 next cycle; remaining beats produce no o_write; next request misses.
//  - Stall i_memAck 10 cycles and insert gaps in i_dataValid -> o_memAddr stable, all 8 beats written in order.

Source files
------------

// File: rtl/clut_cache_loader.sv
// CLUT cache fill controller: checks which 16-colour blocks a primitive needs,
// bursts missing blocks in from VRAM and signals when the whole CLUT is resident.
module clut_cache_loader #(
  parameter int BURST_LEN = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_loadReq,
  input  logic [5:0]  i_clutX,
  input  logic [8:0]  i_clutY,
  input  logic        i_is8bpp,
  input  logic        i_invalidate,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_memReq,
  output logic [17:0] o_memAddr,
  input  logic        i_memAck,
  input  logic        i_dataValid,
  input  logic [31:0] i_data,
  output logic        o_write,
  output logic [3:0]  o_writeBlockIndex,
  output logic [2:0]  o_writeIdxInBlk,
  output logic [31:0] o_Colors
);

  localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REQ   = 3'd2,
    RECV  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [5:0]  clut_x;
  logic [8:0]  clut_y;
  logic        is_8bpp;
  logic [3:0]  n;
  logic [2:0]  beat;
  logic [15:0] valid;
  logic [10:0] tag [16];
  logic        inval_pend;

  logic [5:0]  col;
  logic [3:0]  blk;
  logic [10:0] cur_tag;
  logic        hit, last_n, burst_end, drop;

  // Lookup of the column currently being examined
  always_comb begin
    col       = clut_x + {2'b00, n};
    blk       = col[3:0];
    cur_tag   = {col[5:4], clut_y};
    hit       = valid[blk] && (tag[blk] == cur_tag);
    last_n    = is_8bpp ? (n == 4'd15) : 1'b1;
    burst_end = (state == RECV) && i_dataValid && (beat == LAST_BEAT);
    drop      = inval_pend || i_invalidate;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_loadReq) state_nx = CHECK;
        else           state_nx = IDLE;
      end
      CHECK: begin
        if (i_invalidate) state_nx = CHECK;
        else if (!hit)    state_nx = REQ;
        else if (last_n)  state_nx = DONE;
        else              state_nx = CHECK;
      end
      REQ: begin
        if (i_memAck) state_nx = RECV;
        else          state_nx = REQ;
      end
      RECV: begin
        if (!burst_end)  state_nx = RECV;
        else if (drop)   state_nx = CHECK;
        else if (last_n) state_nx = DONE;
        else             state_nx = CHECK;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, cache tags and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= IDLE;
      clut_x            <= 6'd0;
      clut_y            <= 9'd0;
      is_8bpp           <= 1'b0;
      n                 <= 4'd0;
      beat              <= 3'd0;
      valid             <= 16'd0;
      inval_pend        <= 1'b0;
      for (int i = 0; i < 16; i++) tag[i] <= 11'd0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_memReq          <= 1'b0;
      o_memAddr         <= 18'd0;
      o_write           <= 1'b0;
      o_writeBlockIndex <= 4'd0;
      o_writeIdxInBlk   <= 3'd0;
      o_Colors          <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (i_loadReq) begin
            clut_x  <= i_clutX;
            clut_y  <= i_clutY;
            is_8bpp <= i_is8bpp;
            n       <= 4'd0;
          end
        end
        CHECK: begin
          inval_pend <= 1'b0;
          if (i_invalidate)        n <= 4'd0;
          else if (hit && !last_n) n <= n + 4'd1;
        end
        REQ: begin
          beat <= 3'd0;
          if (i_invalidate) inval_pend <= 1'b1;
        end
        RECV: begin
          if (i_invalidate) inval_pend <= 1'b1;
          if (i_dataValid)  beat <= beat + 3'd1;
          // An invalidate seen at any point during the burst leaves this block invalid
          if (burst_end) begin
            inval_pend <= 1'b0;
            if (drop) begin
              n <= 4'd0;
            end else begin
              valid[blk] <= 1'b1;
              tag[blk]   <= cur_tag;
              if (!last_n) n <= n + 4'd1;
            end
          end
        end
        default: ;
      endcase
      if (i_invalidate) valid <= 16'd0;

      o_busy   <= (state_nx != IDLE);
      o_done   <= (state_nx == DONE);
      o_memReq <= (state_nx == REQ);
      if ((state == CHECK) && (state_nx == REQ)) o_memAddr <= {clut_y, col, 3'b000};
      o_write  <= (state == RECV) && i_dataValid;
      if ((state == RECV) && i_dataValid) begin
        o_writeBlockIndex <= blk;
        o_writeIdxInBlk   <= beat;
        o_Colors          <= i_data;
      end
    end
  end

endmodule

// File: tb/tb_clut_cache_loader.sv
// Randomized bench for clut_cache_loader: a VRAM responder feeds bursts, and a
// block-level cache model predicts the bursts, writes and completion.
module tb_clut_cache_loader;

  logic        i_clk, i_rst, i_loadReq, i_is8bpp, i_invalidate;
  logic [5:0]  i_clutX;
  logic [8:0]  i_clutY;
  logic        o_busy, o_done, o_memReq, i_memAck, i_dataValid, o_write;
  logic [17:0] o_memAddr;
  logic [31:0] i_data, o_Colors;
  logic [3:0]  o_writeBlockIndex;
  logic [2:0]  o_writeIdxInBlk;

  clut_cache_loader dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_loadReq(i_loadReq), .i_clutX(i_clutX),
    .i_clutY(i_clutY), .i_is8bpp(i_is8bpp), .i_invalidate(i_invalidate),
    .o_busy(o_busy), .o_done(o_done), .o_memReq(o_memReq), .o_memAddr(o_memAddr),
    .i_memAck(i_memAck), .i_dataValid(i_dataValid), .i_data(i_data),
    .o_write(o_write), .o_writeBlockIndex(o_writeBlockIndex),
    .o_writeIdxInBlk(o_writeIdxInBlk), .o_Colors(o_Colors)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] seed;
  logic [17:0] burst_q[$];
  logic [38:0] wr_q[$];
  int done_cnt = 0;
  bit addr_bad = 0;
  int ack_wait = -1;
  int gap_max  = 0;
  int inval_beat = -1;
  int rst_beat   = -1;
  bit          mv [16];
  logic [10:0] mt [16];

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] vram(input logic [17:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]} ^ seed;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({o_busy, o_done, o_memReq, o_write, o_memAddr,
                o_writeBlockIndex, o_writeIdxInBlk, o_Colors});
  endfunction

  // Output monitor: records cache writes and completion pulses
  always @(negedge i_clk) begin
    if (o_write) wr_q.push_back({o_writeBlockIndex, o_writeIdxInBlk, o_Colors});
    if (o_done) done_cnt++;
  end

  // VRAM responder: acks with a delay, then returns 8 beats with random gaps
  initial begin
    logic [17:0] addr;
    int d;
    bit do_rst;
    i_memAck = 1'b0; i_dataValid = 1'b0; i_data = 32'd0;
    forever begin
      @(negedge i_clk);
      if (o_memReq && !i_rst) begin
        addr = o_memAddr;
        d = (ack_wait >= 0) ? ack_wait : int'($urandom_range(0, 3));
        repeat (d) begin
          @(negedge i_clk);
          if (!o_memReq || o_memAddr !== addr) addr_bad = 1'b1;
        end
        i_memAck = 1'b1;
        burst_q.push_back(addr);
        @(negedge i_clk);
        i_memAck = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat ($urandom_range(0, gap_max)) @(negedge i_clk);
          i_dataValid = 1'b1;
          i_data = vram(addr | 18'(k));
          if (k == inval_beat) begin i_invalidate = 1'b1; inval_beat = -1; end
          do_rst = (k == rst_beat);
          if (do_rst) begin i_rst = 1'b1; rst_beat = -1; end
          @(negedge i_clk);
          i_dataValid = 1'b0;
          i_invalidate = 1'b0;
          if (do_rst) begin
            i_rst = 1'b0;
            check_eq("rst_mid_burst_outputs", all_outs(), 64'd0);
          end
        end
      end
    end
  end

  task automatic model_clear();
    for (int b = 0; b < 16; b++) mv[b] = 1'b0;
  endtask

  task automatic do_load(input logic [5:0] x, input logic [8:0] y, input logic w8,
                         input int inv_b, output int lat, output int nbursts);
    logic [17:0] exp_q[$];
    logic [17:0] first, a;
    logic [5:0]  col;
    int nb;
    bit inv_used;
    nb = w8 ? 16 : 1;
    for (int n = 0; n < nb; n++) begin
      col = x + 6'(n);
      if (!(mv[col[3:0]] && mt[col[3:0]] == {col[5:4], y})) exp_q.push_back({y, col, 3'b000});
    end
    inv_used = (inv_b >= 0) && (exp_q.size() > 0);
    // First burst still lands, then every block of the request is fetched again
    if (inv_used) begin
      first = exp_q[0];
      exp_q.delete();
      exp_q.push_back(first);
      for (int n = 0; n < nb; n++) begin
        col = x + 6'(n);
        exp_q.push_back({y, col, 3'b000});
      end
    end
    burst_q.delete(); wr_q.delete(); done_cnt = 0; addr_bad = 1'b0;
    inval_beat = inv_used ? inv_b : -1;
    i_clutX = x; i_clutY = y; i_is8bpp = w8; i_loadReq = 1'b1;
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
      i_loadReq = 1'b0;
    end while (!o_done && lat < 4000);
    check_eq("done_seen", 64'(o_done), 64'd1);
    repeat (3) @(negedge i_clk);
    check_eq("done_pulses", 64'(done_cnt), 64'd1);
    check_eq("burst_count", 64'(burst_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < burst_q.size() && i < exp_q.size(); i++)
      check_eq("burst_addr", 64'(burst_q[i]), 64'(exp_q[i]));
    check_eq("write_count", 64'(wr_q.size()), 64'(8 * exp_q.size()));
    for (int k = 0; k < wr_q.size() && k < 8 * exp_q.size(); k++) begin
      a = exp_q[k / 8] | 18'(k % 8);
      check_eq("write_beat", 64'(wr_q[k]), 64'({a[6:3], 3'(k % 8), vram(a)}));
    end
    check_eq("addr_stable", 64'(addr_bad), 64'd0);
    check_eq("idle_after", 64'(o_busy), 64'd0);
    if (inv_used) model_clear();
    for (int n = 0; n < nb; n++) begin
      col = x + 6'(n);
      mv[col[3:0]] = 1'b1;
      mt[col[3:0]] = {col[5:4], y};
    end
    inval_beat = -1;
    nbursts = burst_q.size();
  endtask

  initial begin
    int lat, nbur;
    seed = $urandom;
    i_rst = 1'b1; i_loadReq = 1'b0; i_invalidate = 1'b0;
    i_clutX = 6'd0; i_clutY = 9'd0; i_is8bpp = 1'b0;
    model_clear();
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    check_eq("reset_outputs", all_outs(), 64'd0);

    // Cold 4bpp load, then an identical request that must hit
    do_load(6'd5, 9'd480, 1'b0, -1, lat, nbur);
    check_eq("cold_4bpp_addr", 64'(burst_q.size() > 0 ? burst_q[0] : 18'd0), 64'h3C028);
    do_load(6'd5, 9'd480, 1'b0, -1, lat, nbur);
    check_eq("hit_latency", 64'(lat), 64'd2);
    check_eq("hit_no_burst", 64'(nbur), 64'd0);

    do_load(6'd60, 9'd0, 1'b1, -1, lat, nbur);
    check_eq("cold_8bpp_bursts", 64'(nbur), 64'd16);

    // Reset on beat 3 abandons the burst; trailing beats must be ignored
    gap_max = 0; ack_wait = 0; rst_beat = 3;
    wr_q.delete(); done_cnt = 0;
    i_clutX = 6'd7; i_clutY = 9'd100; i_is8bpp = 1'b0; i_loadReq = 1'b1;
    @(negedge i_clk);
    i_loadReq = 1'b0;
    repeat (40) @(negedge i_clk);
    check_eq("rst_writes", 64'(wr_q.size()), 64'd3);
    check_eq("rst_no_done", 64'(done_cnt), 64'd0);
    check_eq("rst_idle", 64'(o_busy), 64'd0);
    rst_beat = -1;
    model_clear();
    do_load(6'd7, 9'd100, 1'b0, -1, lat, nbur);
    check_eq("after_rst_miss", 64'(nbur), 64'd1);

    model_clear();
    i_invalidate = 1'b1;
    @(negedge i_clk);
    i_invalidate = 1'b0;
    do_load(6'd0, 9'd0, 1'b0, -1, lat, nbur);
    do_load(6'd60, 9'd0, 1'b1, -1, lat, nbur);
    check_eq("skip_blk0_bursts", 64'(nbur), 64'd15);

    do_load(6'd33, 9'd200, 1'b0, 3, lat, nbur);
    check_eq("inval_refetch_bursts", 64'(nbur), 64'd2);
    check_eq("inval_refetch_writes", 64'(wr_q.size()), 64'd16);

    ack_wait = 10; gap_max = 3;
    do_load(6'd20, 9'd300, 1'b0, -1, lat, nbur);

    ack_wait = -1; gap_max = 2;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        i_invalidate = 1'b1;
        @(negedge i_clk);
        i_invalidate = 1'b0;
        model_clear();
      end
      do_load(6'($urandom_range(0, 63)), 9'($urandom_range(0, 2)),
              1'($urandom_range(0, 3) == 0),
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1, lat, nbur);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
